// File: rtl/ram_sp_burst_master.sv
// ram_sp_burst_master
// Initiator-side burst controller for a single-port RAM that has a
// synchronous write and an asynchronous read. It accepts
// {write, addr, len} burst commands and moves one word per beat between
// the RAM port and the wr_* / rd_* streams.
//
// Handshake rule for cmd, wr and rd: a transfer happens on a rising clk
// edge where valid && ready are both high. Valid never waits on ready.
// cmd_ready, wr_ready and rd_valid come only from the current state, so
// no ready signal depends combinationally on its own valid.
module ram_sp_burst_master #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic              done_q, done_d;

    // Next-state and RAM-port/stream outputs. While rst is high every
    // strobe is forced low and the RAM pins read zero, even though the
    // state register only clears at the next edge.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        busy      = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rd_data   = '0;

        if (!rst) begin
            ram_addr = ptr_q;
            case (state_q)
                IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        ptr_d   = cmd_addr;
                        rem_d   = cmd_len;
                        state_d = cmd_write ? WRITE : READ;
                    end
                end

                WRITE: begin
                    wr_ready  = 1'b1;
                    busy      = 1'b1;
                    ram_wdata = wr_data;
                    // wr_ready is constant high here, so a beat is just wr_valid.
                    ram_we    = wr_valid;
                    if (wr_valid) begin
                        ptr_d = ptr_q + 1'b1;
                        rem_d = rem_q - 1'b1;
                        if (rem_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end

                READ: begin
                    rd_valid = 1'b1;
                    busy     = 1'b1;
                    // Asynchronous RAM read: data follows ptr in the same cycle
                    // and stays put while rd_ready stalls, because ptr is held.
                    rd_data  = ram_rdata;
                    if (rd_ready) begin
                        ptr_d = ptr_q + 1'b1;
                        rem_d = rem_q - 1'b1;
                        if (rem_q == '0) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, pointer, beat counter and the registered done pulse. Reset
    // abandons a burst in flight without pulsing done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_sp_burst_master.sv
// Bench for ram_sp_burst_master: a behavioural 16x8 RAM model (synchronous
// write, asynchronous read) sits on the RAM port, driver tasks issue
// directed bursts, and a negedge monitor pops the expected queues on every
// RAM write and every read handshake.
module tb_ram_sp_burst_master;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [1:0]        dbg_state;

  // RAM model and bench-side image of what it should hold
  logic [DATA_W-1:0] mem     [DEPTH];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  // scoreboard queues: writes as {addr, data}, reads as data
  logic [ADDR_W+DATA_W-1:0] exp_w_q[$];
  logic [DATA_W-1:0]        exp_r_q[$];

  int n_chk;
  int n_fail;
  int done_cnt;
  int exp_done;
  logic [DATA_W-1:0] wdat [DEPTH];

  ram_sp_burst_master #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end
  assign ram_rdata = mem[ram_addr];

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rst) begin
      if (ram_we !== 1'b0) chk("we_in_reset", 32'(ram_we), 32'd0);
    end else begin
      if (ram_we === 1'b1) begin
        if (exp_w_q.size() == 0) chk("unexpected_write", {20'd0, ram_addr, ram_wdata}, 32'hFFFF_FFFF);
        else chk("ram_write", {20'd0, ram_addr, ram_wdata}, {20'd0, exp_w_q.pop_front()});
      end
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        if (exp_r_q.size() == 0) chk("unexpected_read", {24'd0, rd_data}, 32'hFFFF_FFFF);
        else chk("rd_data", {24'd0, rd_data}, {24'd0, exp_r_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Returns at posedge+1 of the first burst cycle.
  task automatic issue_cmd(input logic wr, input logic [3:0] a, input logic [3:0] l);
    bit got = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        got = 1;
        break;
      end
    end
    if (!got) chk("cmd_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [3:0] a, input logic [3:0] l);
    logic [3:0] ad;
    issue_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 4'(i);
      wr_valid = 1'b1;
      wr_data  = wdat[i];
      exp_w_q.push_back({ad, wdat[i]});
      exp_mem[ad] = wdat[i];
      @(negedge clk);
      chk("wr_we", 32'(ram_we), 32'd1);
      chk("wr_addr", 32'(ram_addr), 32'(ad));
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    exp_done++;
    @(negedge clk);
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_done_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("wr_done_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wr_done_one_cycle", 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  // pat bit c is rd_ready in burst cycle c (1 beyond bit 15)
  task automatic run_read(input logic [3:0] a, input logic [3:0] l, input logic [15:0] pat);
    int beat = 0;
    int c = 0;
    logic [3:0] ad;
    issue_cmd(1'b0, a, l);
    while (beat <= int'(l) && c < 64) begin
      ad = a + 4'(beat);
      rd_ready = (c < 16) ? pat[c] : 1'b1;
      if (rd_ready) exp_r_q.push_back(exp_mem[ad]);
      @(negedge clk);
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_no_we", 32'(ram_we), 32'd0);
      chk("rd_addr", 32'(ram_addr), 32'(ad));
      chk("rd_data_stable", 32'(rd_data), 32'(exp_mem[ad]));
      @(posedge clk); #1;
      if (rd_ready) beat++;
      c++;
    end
    if (beat <= int'(l)) chk("read_timeout", 32'(beat), 32'(l) + 1);
    rd_ready = 1'b0;
    exp_done++;
    @(negedge clk);
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_done_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_chk = 0; n_fail = 0; done_cnt = 0; exp_done = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
      wdat[i] = '0;
    end

    // reset with activity on every input
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd3; cmd_len = 4'd2;
    wr_valid = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0; cmd_valid = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("post_rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;

    // wrapping write: 14,15,0,1
    wdat[0] = 8'hA0; wdat[1] = 8'hA1; wdat[2] = 8'hA2; wdat[3] = 8'hA3;
    run_write(4'd14, 4'd3);
    chk("mem14", 32'(mem[14]), 32'hA0);
    chk("mem15", 32'(mem[15]), 32'hA1);
    chk("mem0", 32'(mem[0]), 32'hA2);
    chk("mem1", 32'(mem[1]), 32'hA3);

    // stalled read-back, rd_ready 1,0,0,1,1,1
    run_read(4'd14, 4'd3, 16'b1111_1111_1111_1001);

    // single-beat write with a 3-cycle gap, read held behind it
    issue_cmd(1'b1, 4'd5, 4'd0);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd5; cmd_len = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("gap_no_we", 32'(ram_we), 32'd0);
      chk("gap_wr_ready", 32'(wr_ready), 32'd1);
      chk("gap_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b1; wr_data = 8'h5A;
    exp_w_q.push_back({4'd5, 8'h5A});
    exp_mem[5] = 8'h5A;
    @(negedge clk);
    chk("single_we", 32'(ram_we), 32'd1);
    chk("single_addr", 32'(ram_addr), 32'd5);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    exp_done++;
    @(negedge clk);
    chk("single_done", 32'(done), 32'd1);
    chk("b2b_accept_in_done", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rd_ready = 1'b1;
    exp_r_q.push_back(8'h5A);
    @(negedge clk);
    chk("b2b_rd_valid", 32'(rd_valid), 32'd1);
    chk("b2b_rd_data", 32'(rd_data), 32'h5A);
    chk("b2b_done_low", 32'(done), 32'd0);
    @(posedge clk); #1;
    rd_ready = 1'b0;
    exp_done++;
    @(negedge clk);
    chk("b2b_rd_done", 32'(done), 32'd1);
    @(posedge clk); #1;

    // full sweep: data = addr ^ 0xFF
    for (int i = 0; i < DEPTH; i++) wdat[i] = 8'(i) ^ 8'hFF;
    run_write(4'd0, 4'd15);
    for (int i = 0; i < DEPTH; i++) chk("sweep_mem", 32'(mem[i]), 32'(8'(i) ^ 8'hFF));
    run_read(4'd0, 4'd15, 16'hFFFF);

    // write burst of 8 aborted by reset after 3 beats
    issue_cmd(1'b1, 4'd0, 4'd7);
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = wdat[i];
      exp_w_q.push_back({4'(i), wdat[i]});
      exp_mem[i] = wdat[i];
      @(posedge clk); #1;
    end
    rst = 1'b1;
    wr_data = 8'h44;
    @(negedge clk);
    chk("abort_we", 32'(ram_we), 32'd0);
    chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("abort_cmd_ready_back", 32'(cmd_ready), 32'd1);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_no_done_late", 32'(done), 32'd0);

    // final memory and scoreboard state
    for (int i = 0; i < DEPTH; i++) chk("final_mem", 32'(mem[i]), 32'(exp_mem[i]));
    chk("abort_mem3_untouched", 32'(mem[3]), 32'hFC);
    chk("w_queue_empty", 32'(exp_w_q.size()), 32'd0);
    chk("r_queue_empty", 32'(exp_r_q.size()), 32'd0);
    chk("done_pulses", 32'(done_cnt), 32'(exp_done));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
